accum_step: RTL and testbench

Parametrised successor to the board-level accumulator. It adds a registered input value to a running total, or subtracts, loads or clears it, each time a step button is pressed. The step input is synchronised internally and rising-edge detected, and holding the button auto-repeats the operation. The block sits between the DE-series switches/pushbuttons and the LED/HEX display logic inside the top-level wrapper.

---
 rtl/accum_step.sv | 138 +++++++++++++
 tb/tb_accum_step.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/accum_step.sv
// accum_step: step-driven accumulator (add/sub/load/clear) with a
// synchronised, edge-detected, auto-repeating step request.
//
// Ports:
//   CLOCK_50  in  system clock, rising edge
//   Reset     in  synchronous active-high reset
//   Step      in  asynchronous active-high operation request
//   Mode      in  00 add, 01 subtract, 10 load, 11 clear
//   Data      in  operand, zero-extended to ACC_W
//   Acc       out accumulator value
//   Ovf       out sticky overflow/underflow flag
//   Pulse     out one-cycle strobe after each applied operation
//
// Build option: define ACC_SAT_EN to saturate add/subtract instead of
// wrapping; the default build wraps modulo 2^ACC_W.
module accum_step #(
    parameter int DATA_W     = 10,
    parameter int ACC_W      = 16,
    parameter int REPEAT_DLY = 25_000_000
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic              Step,
    input  logic [1:0]        Mode,
    input  logic [DATA_W-1:0] Data,
    output logic [ACC_W-1:0]  Acc,
    output logic              Ovf,
    output logic              Pulse
);

    if (ACC_W < DATA_W) begin : g_width_check
        $error("accum_step: ACC_W must be >= DATA_W");
    end

    localparam int CNT_W = (REPEAT_DLY > 0) ? $clog2(REPEAT_DLY + 1) : 1;
    // A reload of zero leaves the counter idle, so REPEAT_DLY = 0
    // needs no special case.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REPEAT_DLY);

    logic             sync1_q;
    logic             sync2_q;
    logic             edge_q;
    logic [1:0]       fill_q;
    logic             armed_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             pulse_q;

    logic             rise;
    logic             rep;
    logic             fire;
    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   diff;

    assign rise = sync2_q & ~edge_q & armed_q;
    assign rep  = sync2_q & (cnt_q == CNT_W'(1));
    assign fire = rise | rep;

    assign ext  = ACC_W'(Data);
    assign sum  = {1'b0, acc_q} + {1'b0, ext};
    assign diff = {1'b0, acc_q} - {1'b0, ext};

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (fire) begin
            case (Mode)
                2'b00: begin
`ifdef ACC_SAT_EN
                    acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
                    acc_d = sum[ACC_W-1:0];
`endif
                    ovf_d = ovf_q | sum[ACC_W];
                end
                2'b01: begin
`ifdef ACC_SAT_EN
                    acc_d = diff[ACC_W] ? '0 : diff[ACC_W-1:0];
`else
                    acc_d = diff[ACC_W-1:0];
`endif
                    ovf_d = ovf_q | diff[ACC_W];
                end
                2'b10: begin
                    acc_d = ext;
                    ovf_d = 1'b0;
                end
                default: begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= Step;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            // sync2_q only reflects the real Step two edges after reset;
            // before that its zero is the reset value and must not arm.
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && !sync2_q) begin
                armed_q <= 1'b1;
            end
            if (!sync2_q) begin
                cnt_q <= '0;
            end else if (fire) begin
                cnt_q <= RELOAD;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            pulse_q <= fire;
        end
    end

    assign Acc   = acc_q;
    assign Ovf   = ovf_q;
    assign Pulse = pulse_q;

endmodule

// File: tb/tb_accum_step.sv
// tb_accum_step: table-driven and scoreboarded check of accum_step
// with DATA_W = ACC_W = 8 and REPEAT_DLY = 4.
module tb_accum_step;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Step;
    logic [1:0] Mode;
    logic [7:0] Data;
    logic [7:0] Acc;
    logic       Ovf;
    logic       Pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] acc;
        logic       ovf;
        int         at_cyc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic [7:0] acc;
        logic       ovf;
    } vec_t;

    vec_t vt[15];

    accum_step #(
        .DATA_W(8),
        .ACC_W(8),
        .REPEAT_DLY(4)
    ) dut (
        .CLOCK_50(clk),
        .Reset(Reset),
        .Step(Step),
        .Mode(Mode),
        .Data(Data),
        .Acc(Acc),
        .Ovf(Ovf),
        .Pulse(Pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Every Pulse must match the oldest expected fire, in value and edge.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (Pulse) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", int'(Pulse), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("acc", int'(Acc), int'(e.acc));
                chk("ovf", int'(Ovf), int'(e.ovf));
                chk("fire_edge", cyc, e.at_cyc);
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_fire(input logic [7:0] a, input logic o,
                               input int at);
        exp_t e;
        e.acc    = a;
        e.ovf    = o;
        e.at_cyc = at;
        sb.push_back(e);
    endtask

    // Called on a negedge: Step is first sampled at cyc+1, fires at cyc+3.
    task automatic press(input logic [1:0] m, input logic [7:0] d,
                         input logic [7:0] a, input logic o);
        Mode = m;
        Data = d;
        expect_fire(a, o, cyc + 3);
        Step = 1'b1;
        wait_n(2);
        Step = 1'b0;
        wait_n(5);
    endtask

    initial begin
        int c;
        logic [7:0] w_ovf_add;
        logic [7:0] w_sub;
        logic [7:0] w_wrap;

`ifdef ACC_SAT_EN
        w_ovf_add = 8'd255;
        w_sub     = 8'd0;
        w_wrap    = 8'd255;
`else
        w_ovf_add = 8'd4;
        w_sub     = 8'd254;
        w_wrap    = 8'd0;
`endif
        vt[0]  = '{2'b00, 8'd5,   8'd5,   1'b0};
        vt[1]  = '{2'b00, 8'd5,   8'd10,  1'b0};
        vt[2]  = '{2'b00, 8'd5,   8'd15,  1'b0};
        vt[3]  = '{2'b10, 8'd250, 8'd250, 1'b0};
        vt[4]  = '{2'b00, 8'd10,  w_ovf_add, 1'b1};
`ifdef ACC_SAT_EN
        vt[5]  = '{2'b00, 8'd1,   8'd255, 1'b1};
`else
        vt[5]  = '{2'b00, 8'd1,   8'd5,   1'b1};
`endif
        vt[6]  = '{2'b10, 8'd3,   8'd3,   1'b0};
        vt[7]  = '{2'b01, 8'd5,   w_sub,  1'b1};
        vt[8]  = '{2'b11, 8'd77,  8'd0,   1'b0};
        vt[9]  = '{2'b00, 8'd255, 8'd255, 1'b0};
        vt[10] = '{2'b01, 8'd255, 8'd0,   1'b0};
        vt[11] = '{2'b01, 8'd0,   8'd0,   1'b0};
        vt[12] = '{2'b10, 8'd128, 8'd128, 1'b0};
        vt[13] = '{2'b00, 8'd127, 8'd255, 1'b0};
        vt[14] = '{2'b00, 8'd1,   w_wrap, 1'b1};

        Reset = 1'b1;
        Step  = 1'b0;
        Mode  = 2'b00;
        Data  = 8'd0;
        wait_n(3);
        Reset = 1'b0;
        wait_n(1);
        chk("rst_acc",   int'(Acc),   0);
        chk("rst_ovf",   int'(Ovf),   0);
        chk("rst_pulse", int'(Pulse), 0);
        wait_n(4);

        foreach (vt[i]) begin
            press(vt[i].mode, vt[i].data, vt[i].acc, vt[i].ovf);
        end
        press(2'b10, 8'd0, 8'd0, 1'b0);

        // Auto-repeat: Step sampled high on 20 edges -> 5 fires.
        c = cyc;
        Mode = 2'b00;
        Data = 8'd1;
        for (int n = 0; n < 5; n++) begin
            expect_fire(8'(n + 1), 1'b0, c + 3 + 4 * n);
        end
        Step = 1'b1;
        wait_n(20);
        Step = 1'b0;
        wait_n(8);
        chk("rep_acc", int'(Acc), 5);

        // Mode change between repeats.
        press(2'b11, 8'd0, 8'd0, 1'b0);
        c = cyc;
        Mode = 2'b00;
        Data = 8'd2;
        expect_fire(8'd2, 1'b0, c + 3);
        expect_fire(8'd0, 1'b0, c + 7);
        expect_fire(w_sub, 1'b1, c + 11);
        Step = 1'b1;
        wait_n(5);
        Mode = 2'b01;
        wait_n(7);
        Step = 1'b0;
        wait_n(8);

        // Reset while Step is held: no fire until a fresh press.
        c = cyc;
        Mode = 2'b10;
        Data = 8'd9;
        expect_fire(8'd9, 1'b0, c + 3);
        Step = 1'b1;
        wait_n(5);
        Reset = 1'b1;
        wait_n(1);
        Reset = 1'b0;
        Mode = 2'b00;
        Data = 8'd3;
        wait_n(12);
        chk("hold_acc", int'(Acc), 0);
        chk("hold_ovf", int'(Ovf), 0);
        Step = 1'b0;
        wait_n(6);
        press(2'b00, 8'd7, 8'd7, 1'b0);
        chk("post_acc", int'(Acc), 7);

        wait_n(4);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
